// File: rtl/wrr_lock_arbiter_if.sv
// Request/grant bundle between N requesters, the shared resource and the arbiter.
// Latency: none (wires only).
// Backpressure: the resource holds a grant by withholding done; requesters hold req.
//
// Signals:
//   req     requester -> arbiter   request vector, bit i = requester i
//   weight  requester -> arbiter   per-requester weight at [i*CW +: CW]; 0 behaves as 1
//   done    resource  -> arbiter   1-cycle pulse ending the current transaction
//   gnt     arbiter   -> resource  one-hot grant (zero when idle)
//   gnt_id  arbiter   -> resource  binary index of the granted requester, 0 when idle
//   busy    arbiter   -> resource  high while a grant is held
interface wrr_lock_arbiter_if #(
    parameter int N  = 4,
    parameter int CW = 4
) ();
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    req;
    logic [N*CW-1:0] weight;
    logic            done;
    logic [N-1:0]    gnt;
    logic [IW-1:0]   gnt_id;
    logic            busy;

    // Requester/resource side of the bundle.
    modport master (
        output req,
        output weight,
        output done,
        input  gnt,
        input  gnt_id,
        input  busy
    );

    // Arbiter side of the bundle.
    modport slave (
        input  req,
        input  weight,
        input  done,
        output gnt,
        output gnt_id,
        output busy
    );
endinterface

// File: rtl/wrr_lock_arbiter.sv
// Weighted round-robin arbiter with transaction lock over one shared resource.
// Latency: req -> gnt 1 cycle from idle; back-to-back re-grant on done with no idle gap.
// Backpressure: a grant is held until done; dropping req does not release it.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset; overrides done in the same cycle
//   bus   wrr_lock_arbiter_if.slave: req/weight/done in, gnt/gnt_id/busy out
//
// Outputs are decoded purely from state registers, so they carry no
// combinational path from any input.
module wrr_lock_arbiter #(
    parameter int N  = 4,
    parameter int CW = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    wrr_lock_arbiter_if.slave     bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [IW-1:0]   cur_q,   cur_d;     // granted requester
    logic [IW-1:0]   ptr_q,   ptr_d;     // round-robin scan start
    logic [CW-1:0]   credit_q, credit_d; // extra transactions left for cur

    // Scan results
    logic [IW-1:0]   scan_base;
    logic            sel_found;
    logic [IW-1:0]   sel_idx;
    logic [IW-1:0]   rot_ptr;

    // Output decode
    logic [N-1:0]    gnt_c;
    logic [IW-1:0]   gnt_id_c;
    logic            busy_c;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Index after idx, wrapping N-1 -> 0 (also correct for non-power-of-2 N).
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        logic [IW-1:0] r;
        if (int'(idx) >= N - 1) begin
            r = '0;
        end else begin
            r = idx + IW'(1);
        end
        return r;
    endfunction

    // Credit loaded at grant time: max(weight,1) - 1, so a weight of 0 or 1
    // both give exactly one transaction before rotation.
    function automatic logic [CW-1:0] load_credit(input logic [N*CW-1:0] w,
                                                  input logic [IW-1:0]   idx);
        logic [CW-1:0] f;
        f = w[int'(idx)*CW +: CW];
        if (f == '0) begin
            return '0;
        end
        return f - CW'(1);
    endfunction

    // ------------------------------------------------------------------
    // Requester scan: first set bit at or above scan_base, wrapping.
    // In IDLE the scan starts at the pointer; in GRANT it starts one past
    // the current holder, which is also the pointer written on rotation.
    // The holder is scanned last, so it only wins when it is alone.
    // ------------------------------------------------------------------
    assign rot_ptr   = next_idx(cur_q);
    assign scan_base = (state_q == ST_IDLE) ? ptr_q : rot_ptr;

    always_comb begin
        int k;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < N; i++) begin
            k = int'(scan_base) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!sel_found && bus.req[k]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(k);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cur_q    <= '0;
            ptr_q    <= '0;
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;

        case (state_q)
            ST_IDLE: begin
                // done is meaningless without a grant and is ignored here.
                if (sel_found) begin
                    state_d  = ST_GRANT;
                    cur_d    = sel_idx;
                    credit_d = load_credit(bus.weight, sel_idx);
                end
            end

            ST_GRANT: begin
                if (bus.done) begin
                    if ((credit_q != '0) && bus.req[cur_q]) begin
                        // Holder still has credit and still wants the resource.
                        credit_d = credit_q - CW'(1);
                    end else begin
                        ptr_d = rot_ptr;
                        if (sel_found) begin
                            cur_d    = sel_idx;
                            credit_d = load_credit(bus.weight, sel_idx);
                        end else begin
                            state_d  = ST_IDLE;
                            cur_d    = '0;
                            credit_d = '0;
                        end
                    end
                end
            end

            default: begin
                state_d  = ST_IDLE;
                cur_d    = '0;
                credit_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (decoded from registers only)
    // ------------------------------------------------------------------
    always_comb begin
        gnt_c    = '0;
        gnt_id_c = '0;
        busy_c   = 1'b0;
        if (state_q == ST_GRANT) begin
            gnt_c[cur_q] = 1'b1;
            gnt_id_c     = cur_q;
            busy_c       = 1'b1;
        end
    end

    assign bus.gnt    = gnt_c;
    assign bus.gnt_id = gnt_id_c;
    assign bus.busy   = busy_c;

endmodule

// File: tb/tb_wrr_lock_arbiter.sv
// Directed bench for wrr_lock_arbiter: cycle table plus hand-written corner sequences.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: bench drives done explicitly to end each transaction.
module tb_wrr_lock_arbiter;
    localparam int N  = 4;
    localparam int CW = 4;

    localparam logic [15:0] W_ONES = 16'h1111;   // all weights 1
    localparam logic [15:0] W_MIX  = 16'h2113;   // w3=2 w2=1 w1=1 w0=3

    logic clk;
    logic rst;

    wrr_lock_arbiter_if #(.N(N), .CW(CW)) bus ();

    wrr_lock_arbiter #(.N(N), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [15:0] weight;
        logic        done;
        logic [3:0]  gnt;
        logic [1:0]  id;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [3:0] q, input logic [15:0] w,
                       input logic d, input logic [3:0] g, input logic [1:0] id);
        vec_t v;
        v.rst = r; v.req = q; v.weight = w; v.done = d; v.gnt = g; v.id = id;
        tbl.push_back(v);
    endtask

    // Drive one cycle of inputs, let the edge happen, sample just after it.
    task automatic step(input logic r, input logic [3:0] q, input logic [15:0] w,
                        input logic d);
        rst        = r;
        bus.req    = q;
        bus.weight = w;
        bus.done   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [3:0] eg, input logic [1:0] eid);
        n_cmp++;
        if (bus.gnt !== eg || bus.gnt_id !== eid || bus.busy !== (|eg)) begin
            n_bad++;
            $display("FAIL %s: got gnt=%b id=%0d busy=%b, expected gnt=%b id=%0d busy=%b",
                     nm, bus.gnt, bus.gnt_id, bus.busy, eg, eid, |eg);
        end
    endtask

    // ------------------------------------------------------------------
    // Per-cycle invariants, sampled on the falling edge.
    // ------------------------------------------------------------------
    logic       chk_en    = 1'b0;
    logic       have_prev = 1'b0;
    logic [3:0] prev_gnt;
    logic       prev_done;
    logic       prev_rst;

    always @(negedge clk) begin
        if (chk_en) begin
            logic [1:0] exp_id;
            exp_id = 2'd0;
            for (int i = 0; i < N; i++) begin
                if (bus.gnt[i]) exp_id = 2'(i);
            end

            n_cmp++;
            if (!$onehot0(bus.gnt)) begin
                n_bad++;
                $display("FAIL onehot: gnt=%b is not one-hot or zero", bus.gnt);
            end
            n_cmp++;
            if (bus.gnt_id !== exp_id) begin
                n_bad++;
                $display("FAIL gnt_id_consistent: gnt_id=%0d, gnt=%b implies %0d",
                         bus.gnt_id, bus.gnt, exp_id);
            end
            n_cmp++;
            if (bus.busy !== (|bus.gnt)) begin
                n_bad++;
                $display("FAIL busy_consistent: busy=%b, gnt=%b", bus.busy, bus.gnt);
            end
            // A held grant may only change across an edge that saw done or rst.
            if (have_prev && !prev_done && !prev_rst && prev_gnt != 4'b0000) begin
                n_cmp++;
                if (bus.gnt !== prev_gnt) begin
                    n_bad++;
                    $display("FAIL gnt_stable: gnt=%b changed from %b without done/rst",
                             bus.gnt, prev_gnt);
                end
            end
            prev_gnt  = bus.gnt;
            prev_done = bus.done;
            prev_rst  = rst;
            have_prev = 1'b1;
        end
    end

    initial begin
        rst        = 1'b1;
        bus.req    = 4'b0000;
        bus.weight = 16'h0000;
        bus.done   = 1'b0;

        // ---------------- table: reset, rotation, weights, single requester
        // Reset held with all requests up.
        add(1, 4'b1111, W_ONES, 0, 4'b0000, 2'd0);
        add(1, 4'b1111, W_ONES, 0, 4'b0000, 2'd0);
        add(1, 4'b1111, W_ONES, 0, 4'b0000, 2'd0);
        // Release: grant 0 one cycle later, then done every 3rd cycle.
        add(0, 4'b1111, W_ONES, 0, 4'b0001, 2'd0);
        add(0, 4'b1111, W_ONES, 0, 4'b0001, 2'd0);
        add(0, 4'b1111, W_ONES, 0, 4'b0001, 2'd0);
        add(0, 4'b1111, W_ONES, 1, 4'b0010, 2'd1);
        add(0, 4'b1111, W_ONES, 0, 4'b0010, 2'd1);
        add(0, 4'b1111, W_ONES, 0, 4'b0010, 2'd1);
        add(0, 4'b1111, W_ONES, 1, 4'b0100, 2'd2);
        add(0, 4'b1111, W_ONES, 0, 4'b0100, 2'd2);
        add(0, 4'b1111, W_ONES, 0, 4'b0100, 2'd2);
        add(0, 4'b1111, W_ONES, 1, 4'b1000, 2'd3);
        add(0, 4'b1111, W_ONES, 0, 4'b1000, 2'd3);
        add(0, 4'b1111, W_ONES, 0, 4'b1000, 2'd3);
        // Wrap to 0; mixed weights sampled here give requester 0 credit 2.
        add(0, 4'b1111, W_MIX,  1, 4'b0001, 2'd0);
        // Done every 2 cycles: ids 0,0,0,1,2,3,3,0.
        add(0, 4'b1111, W_MIX,  0, 4'b0001, 2'd0);
        add(0, 4'b1111, W_MIX,  1, 4'b0001, 2'd0);
        add(0, 4'b1111, W_MIX,  0, 4'b0001, 2'd0);
        add(0, 4'b1111, W_MIX,  1, 4'b0001, 2'd0);
        add(0, 4'b1111, W_MIX,  0, 4'b0001, 2'd0);
        add(0, 4'b1111, W_MIX,  1, 4'b0010, 2'd1);
        add(0, 4'b1111, W_MIX,  0, 4'b0010, 2'd1);
        add(0, 4'b1111, W_MIX,  1, 4'b0100, 2'd2);
        add(0, 4'b1111, W_MIX,  0, 4'b0100, 2'd2);
        add(0, 4'b1111, W_MIX,  1, 4'b1000, 2'd3);
        add(0, 4'b1111, W_MIX,  0, 4'b1000, 2'd3);
        add(0, 4'b1111, W_MIX,  1, 4'b1000, 2'd3);
        add(0, 4'b1111, W_MIX,  0, 4'b1000, 2'd3);
        add(0, 4'b1111, W_MIX,  1, 4'b0001, 2'd0);
        // Holder 0 has credit left but dropped req: rotate to lone requester 1.
        add(0, 4'b0010, W_ONES, 1, 4'b0010, 2'd1);
        add(0, 4'b0010, W_ONES, 0, 4'b0010, 2'd1);
        // Lone requester re-granted to itself.
        add(0, 4'b0010, W_ONES, 1, 4'b0010, 2'd1);
        add(0, 4'b0010, W_ONES, 0, 4'b0010, 2'd1);
        // Drop req with done: idle; done in idle is ignored.
        add(0, 4'b0000, W_ONES, 1, 4'b0000, 2'd0);
        add(0, 4'b0000, W_ONES, 0, 4'b0000, 2'd0);
        add(0, 4'b0000, W_ONES, 1, 4'b0000, 2'd0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].weight, tbl[i].done);
            chk_en = 1'b1;
            check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].id);
        end

        // ---------------- transaction lock (pointer is 2 after the idle above)
        step(0, 4'b0100, W_ONES, 0);
        check("lock_grant", 4'b0100, 2'd2);
        for (int c = 0; c < 5; c++) begin
            step(0, 4'b0000, W_ONES, 0);
            check($sformatf("lock_hold%0d", c), 4'b0100, 2'd2);
        end
        step(0, 4'b1001, W_ONES, 1);
        check("lock_release", 4'b1000, 2'd3);

        // ---------------- reset mid-transaction with credit outstanding
        // Requester 3 alone, weight 3: re-granted with credit 2.
        step(0, 4'b1000, 16'h3111, 1);
        check("regrant_w3", 4'b1000, 2'd3);
        // Reset overrides done in the same cycle.
        step(1, 4'b1000, 16'h3111, 1);
        check("rst_abandon", 4'b0000, 2'd0);
        // Pointer back at 0; weight 0 on requester 0 behaves as 1.
        step(0, 4'b1001, 16'h1110, 0);
        check("post_rst_ptr0", 4'b0001, 2'd0);
        step(0, 4'b1001, 16'h1110, 1);
        check("weight0_as_1", 4'b1000, 2'd3);

        step(0, 4'b0000, W_ONES, 0);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
